// File: rtl/softmax_seq_ctrl_if.sv
// Control/status bundle between the softmax sequencer and its host/datapath.
// master drives run control; slave is the sequencer itself.
interface softmax_seq_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W:0]   vec_len;
    logic              hold;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] address;
    logic [1:0]        phase;
    logic              acc_clr;
    logic              dv;
    logic              dv_first;
    logic              dv_last;
    logic [1:0]        dv_phase;
    logic              busy;
    logic              done;

    modport master (
        output start, vec_len, hold, abort,
        input  rd_en, address, phase, acc_clr,
        input  dv, dv_first, dv_last, dv_phase, busy, done
    );

    modport slave (
        input  start, vec_len, hold, abort,
        output rd_en, address, phase, acc_clr,
        output dv, dv_first, dv_last, dv_phase, busy, done
    );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: three bounded read passes (MAX, SUM, NORM) with
// per-pass accumulator clear and a read-latency-aligned tag pipe.
module softmax_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input logic               clock,
    input logic               reset,
    softmax_seq_ctrl_if.slave sif
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR1, S_MAX,  S_DRN1,
        S_CLR2, S_SUM,  S_DRN2, S_CLR3,
        S_NORM, S_DRN3, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    // tag layout: {valid, first, last, phase[1:0]}
    logic [4:0]        r_pipe [RD_LAT];

    logic [LEN_W-1:0]  w_len_in;
    logic              w_act;
    logic              w_hold;
    logic              w_abort;
    logic              w_issue;
    logic              w_clr;
    logic              w_drn;
    logic              w_first;
    logic              w_last;
    logic              w_drn_end;
    logic              w_rd;
    logic              w_dv;
    logic [1:0]        w_phase;
    logic [4:0]        w_tag;

    assign w_act     = (r_state != S_IDLE);
    assign w_hold    = sif.hold & w_act;
    assign w_abort   = sif.abort & w_act;
    assign w_len_in  = (sif.vec_len > MAX_LEN) ? MAX_LEN : sif.vec_len;
    assign w_issue   = (r_state == S_MAX) || (r_state == S_SUM) ||
                       (r_state == S_NORM);
    assign w_clr     = (r_state == S_CLR1) || (r_state == S_CLR2) ||
                       (r_state == S_CLR3);
    assign w_drn     = (r_state == S_DRN1) || (r_state == S_DRN2) ||
                       (r_state == S_DRN3);
    assign w_first   = (r_addr == '0);
    assign w_last    = ({1'b0, r_addr} == (r_len - LEN_W'(1)));
    assign w_drn_end = (r_cnt == CNT_END);
    assign w_rd      = w_issue & ~w_hold;
    assign w_tag     = {w_rd, w_rd & w_first, w_rd & w_last, w_phase};
    assign w_dv      = r_pipe[RD_LAT-1][4] & ~w_hold;

    always_comb begin
        w_phase = 2'd0;
        unique case (r_state)
            S_CLR1, S_MAX, S_DRN1:  w_phase = 2'd1;
            S_CLR2, S_SUM, S_DRN2:  w_phase = 2'd2;
            S_CLR3, S_NORM, S_DRN3: w_phase = 2'd3;
            default:                w_phase = 2'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (sif.start)
                w_next = (w_len_in == '0) ? S_DONE : S_CLR1;
        end else if (!w_hold) begin
            unique case (r_state)
                S_CLR1:  w_next = S_MAX;
                S_MAX:   if (w_last) w_next = S_DRN1;
                S_DRN1:  if (w_drn_end) w_next = S_CLR2;
                S_CLR2:  w_next = S_SUM;
                S_SUM:   if (w_last) w_next = S_DRN2;
                S_DRN2:  if (w_drn_end) w_next = S_CLR3;
                S_CLR3:  w_next = S_NORM;
                S_NORM:  if (w_last) w_next = S_DRN3;
                S_DRN3:  if (w_drn_end) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len  <= '0;
            r_addr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else if (w_abort) begin
            r_addr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else if (!w_hold) begin
            if ((r_state == S_IDLE) && sif.start)
                r_len <= w_len_in;
            // natural wrap covers the full 2**ADDR_W length
            if (w_issue)
                r_addr <= r_addr + ADDR_W'(1);
            if (w_drn) begin
                r_cnt <= w_drn_end ? '0 : r_cnt + CNT_W'(1);
                if (w_drn_end) r_addr <= '0;
            end
            r_pipe[0] <= w_tag;
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign sif.rd_en    = w_rd;
    assign sif.address  = r_addr;
    assign sif.phase    = w_phase;
    assign sif.acc_clr  = w_clr & ~w_hold;
    assign sif.dv       = w_dv;
    assign sif.dv_first = r_pipe[RD_LAT-1][3] & w_dv;
    assign sif.dv_last  = r_pipe[RD_LAT-1][2] & w_dv;
    assign sif.dv_phase = r_pipe[RD_LAT-1][1:0];
    assign sif.busy     = w_act & ~((r_state == S_DONE) & ~w_hold);
    assign sif.done     = (r_state == S_DONE) & ~w_hold & ~sif.abort;
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl: expected reads and dv tags are queued
// when a run is launched and popped as the sequencer produces them.
module tb_softmax_seq_ctrl;
    logic clk;
    logic rst_n;

    softmax_seq_ctrl_if #(.ADDR_W(10)) sif ();

    softmax_seq_ctrl #(.ADDR_W(10), .RD_LAT(2)) dut (
        .clock (clk),
        .reset (rst_n),
        .sif   (sif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ecnt = 0;
    int t0 = 0;
    int n_done = 0;
    int n_clr = 0;
    int done_lat = 0;

    logic [11:0] q_rd [$];
    logic [3:0]  q_dv [$];
    logic [11:0] e_rd;
    logic [3:0]  e_dv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int len);
        int l;
        logic [1:0] pp;
        logic f;
        logic la;
        l = (len > 1024) ? 1024 : len;
        for (int p = 1; p <= 3; p++) begin
            for (int i = 0; i < l; i++) begin
                pp = 2'(p);
                f  = (i == 0);
                la = (i == l - 1);
                q_rd.push_back({pp, 10'(i)});
                q_dv.push_back({pp, f, la});
            end
        end
    endtask

    task automatic start_run(input int len);
        push_run(len);
        n_done = 0;
        n_clr = 0;
        sif.vec_len = 11'(len);
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = ecnt;
        sif.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && n_done == 0; i++) @(posedge clk);
        chk("done_seen", n_done, 1);
        #1;
    endtask

    task automatic chk_queues(input string tag);
        chk({tag, "_rd_left"}, q_rd.size(), 0);
        chk({tag, "_dv_left"}, q_dv.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.rd_en) begin
                if (q_rd.size() == 0) begin
                    chk("rd_extra", sif.rd_en, 0);
                end else begin
                    e_rd = q_rd.pop_front();
                    chk("rd_addr", {sif.phase, sif.address}, e_rd);
                end
            end
            if (sif.dv) begin
                if (q_dv.size() == 0) begin
                    chk("dv_extra", sif.dv, 0);
                end else begin
                    e_dv = q_dv.pop_front();
                    chk("dv_tag",
                        {sif.dv_phase, sif.dv_first, sif.dv_last}, e_dv);
                end
            end
            if (sif.acc_clr) n_clr++;
            if (sif.done) begin
                n_done++;
                done_lat = ecnt - t0 + 1;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        sif.start = 1'b0;
        sif.vec_len = '0;
        sif.hold = 1'b0;
        sif.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {sif.rd_en, sif.address, sif.phase, sif.acc_clr,
                           sif.dv, sif.dv_first, sif.dv_last, sif.dv_phase,
                           sif.busy, sif.done}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // len=4, with a start pulse mid-run that must be ignored
        start_run(4);
        chk("len4_busy", sif.busy, 1);
        repeat (3) @(posedge clk);
        #1;
        sif.vec_len = 11'd1;
        sif.start = 1'b1;
        @(posedge clk);
        #1 sif.start = 1'b0;
        wait_done(100);
        chk("len4_lat", done_lat, 22);
        chk("len4_clr", n_clr, 3);
        chk("len4_idle", sif.busy, 0);
        chk_queues("len4");

        start_run(1);
        chk("len1_busy", sif.busy, 1);
        wait_done(100);
        chk("len1_lat", done_lat, 13);
        chk("len1_clr", n_clr, 3);
        chk_queues("len1");

        start_run(0);
        wait_done(10);
        chk("len0_lat_le2", done_lat <= 2, 1);
        chk("len0_clr", n_clr, 0);
        repeat (5) @(posedge clk);
        #1 chk("len0_single_done", n_done, 1);

        // hold during SUM cycles 16..18, address 3 pending
        start_run(8);
        repeat (15) @(posedge clk);
        #1 sif.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_quiet", {sif.rd_en, sif.dv, sif.acc_clr}, 0);
            chk("hold_addr", sif.address, 3);
            @(posedge clk);
        end
        #1 sif.hold = 1'b0;
        wait_done(200);
        chk("len8_hold_lat", done_lat, 37);
        chk_queues("len8");

        start_run(1024);
        repeat (1025) @(posedge clk);
        @(negedge clk);
        chk("wrap_addr", {sif.rd_en, sif.address}, 0);
        chk("wrap_phase", sif.phase, 1);
        wait_done(4000);
        chk("len1024_lat", done_lat, 3082);
        chk("len1024_clr", n_clr, 3);
        chk_queues("len1024");

        start_run(2000);
        wait_done(4000);
        chk("clamp_lat", done_lat, 3082);
        chk_queues("clamp");

        // abort in the second NORM issue cycle
        start_run(4);
        repeat (16) @(posedge clk);
        #1 sif.abort = 1'b1;
        @(posedge clk);
        #1 sif.abort = 1'b0;
        q_rd.delete();
        q_dv.delete();
        @(negedge clk);
        chk("abort_idle", {sif.busy, sif.phase, sif.rd_en, sif.dv,
                           sif.acc_clr}, 0);
        repeat (10) @(posedge clk);
        #1 chk("abort_no_done", n_done, 0);

        // asynchronous reset in the middle of MAX
        start_run(8);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {sif.rd_en, sif.address, sif.phase, sif.acc_clr,
                             sif.dv, sif.dv_first, sif.dv_last, sif.dv_phase,
                             sif.busy, sif.done}, 0);
        q_rd.delete();
        q_dv.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", sif.busy, 0);

        start_run(2);
        wait_done(100);
        chk("len2_lat", done_lat, 16);
        chk_queues("len2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
